// File: rtl/bench_bist_ctrl.sv
// bench_bist_ctrl
// Built-in self-test controller for the bench_comb block. It runs a 32-bit
// LFSR pattern generator and a 32-bit MISR response compactor over
// PAT_COUNT patterns, then compares the final signature against a golden
// value.
//
// Parameters:
//   PAT_COUNT  patterns applied per run (1..65535)
//   SEED       initial LFSR state (0 is replaced by 1)
//   POLY       shared LFSR/MISR feedback polynomial
//
// Ports:
//   clk        single clock, all state on rising edge
//   rst        asynchronous active-high reset
//   start      begin a run (sampled only in IDLE)
//   abort      end a run early, back to IDLE with no done pulse
//   golden     expected signature
//   dut_in     registered pattern driven to bench_comb (LFSR word replicated)
//   dut_out    bench_comb response, absorbed into the MISR every RUN cycle
//   busy       high while in RUN
//   done       one-cycle pulse at end of run
//   pass       signature == golden, captured on entry to DONE
//   signature  MISR contents
//   pat_cnt    patterns applied in the current or last run
//   rare_cnt   RUN cycles with dut_out[0]==1 (saturating)
//
// Optional feature macro: BIST_RARE_MON_EN
//   defined   -> rare_cnt counts rare AND-node activations
//   undefined -> rare_cnt is tied to 0 and no counter exists
module bench_bist_ctrl #(
  parameter int unsigned PAT_COUNT = 256,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter logic [31:0] POLY      = 32'h8020_0003
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  golden,
  output logic [177:0] dut_in,
  input  logic [122:0] dut_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [31:0]  signature,
  output logic [15:0]  pat_cnt,
  output logic [15:0]  rare_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] LAST_CNT = 16'(PAT_COUNT - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [31:0] fold;
  logic [31:0] sig_next;
  logic        load_run;
  logic        step_run;
  logic        last_pat;

  // The 178-bit pattern is the 32-bit LFSR word repeated from bit 0 upward,
  // so bit i carries word bit (i mod 32); the top 18 bits are a partial copy.
  function automatic logic [177:0] replicate(input logic [31:0] w);
    return {w[17:0], {5{w}}};
  endfunction

  // Response folding and the shared Galois-style shift/feedback step for
  // both the pattern generator and the signature register.
  assign fold      = dut_out[31:0] ^ dut_out[63:32] ^ dut_out[95:64] ^
                     {5'b0, dut_out[122:96]};
  assign lfsr_next = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? POLY : 32'd0);
  assign sig_next  = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'd0) ^ fold;

  // pat_cnt still holds the pre-increment count here, so the last RUN cycle
  // is the one where it equals PAT_COUNT-1.
  assign last_pat = (pat_cnt == LAST_CNT);
  assign load_run = (state == IDLE) && start && !abort;
  assign step_run = (state == RUN) && !abort;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort wins over both start and end-of-count.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (last_pat) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Pattern generator, MISR, pattern counter and verdict. Nothing here moves
  // outside a load or a non-aborted RUN cycle, so after an abort or a finished
  // run the last pattern, signature and count simply stay put. pass is
  // cleared when a run starts, so an aborted run leaves it at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= SEED_EFF;
      dut_in    <= '0;
      signature <= '0;
      pat_cnt   <= '0;
      pass      <= 1'b0;
    end else if (load_run) begin
      lfsr      <= SEED_EFF;
      dut_in    <= replicate(SEED_EFF);
      signature <= '0;
      pat_cnt   <= '0;
      pass      <= 1'b0;
    end else if (step_run) begin
      lfsr      <= lfsr_next;
      dut_in    <= replicate(lfsr_next);
      signature <= sig_next;
      pat_cnt   <= pat_cnt + 16'd1;
      if (last_pat) pass <= (sig_next == golden);
    end
  end

`ifdef BIST_RARE_MON_EN
  logic [15:0] rare_q;

  // Counts RUN cycles where the rare AND node (dut_out[0]) fires; it sticks
  // at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rare_q <= '0;
    end else if (load_run) begin
      rare_q <= '0;
    end else if (step_run && dut_out[0] && (rare_q != 16'hFFFF)) begin
      rare_q <= rare_q + 16'd1;
    end
  end

  assign rare_cnt = rare_q;
`else
  assign rare_cnt = 16'd0;
`endif

endmodule
